// File: rtl/adc_stats_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_stats_pkg
//  Description : Shared constants and types for the ADC statistics framer.
//                Frame geometry, word-index constants, FSM state encoding
//                and the default header byte.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_stats_pkg;

    localparam int FRAME_WORDS = 6;

    // Position of each field inside the 6-word status frame
    localparam logic [2:0] W_HDR    = 3'd0;
    localparam logic [2:0] W_DC     = 3'd1;
    localparam logic [2:0] W_PEAK   = 3'd2;
    localparam logic [2:0] W_PWR_HI = 3'd3;
    localparam logic [2:0] W_PWR_LO = 3'd4;
    localparam logic [2:0] W_FLAGS  = 3'd5;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/stats_req_timer.sv
`default_nettype none
// ============================================================================
//  Module      : stats_req_timer
//  Description : Free-running periodic request generator. Emits a one-cycle
//                tick on the clock edge where the PERIOD_BITS-wide counter
//                wraps back to zero, i.e. one tick every 2^PERIOD_BITS clocks.
//                PERIOD_BITS = 0 removes the counter and ties tick low.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clock  in   sole clock
//    reset  in   synchronous active-high reset (counter -> 0)
//    tick   out  one-cycle periodic request strobe
// ============================================================================
module stats_req_timer #(
    parameter int PERIOD_BITS = 0
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    generate
        if (PERIOD_BITS > 0) begin : g_timer
            logic [PERIOD_BITS-1:0] r_count;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + PERIOD_BITS'(1);
                end
            end

            // All-ones means the counter returns to zero on this edge
            assign tick = &r_count;
        end else begin : g_no_timer
            logic w_unused_inputs;
            assign w_unused_inputs = clock ^ reset;
            assign tick            = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/adc_stats_framer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_stats_framer
//  Description : Snapshots the peak/DC/power detector results on request and
//                serialises them as a 6-word, 16-bit status frame over a
//                valid/ready handshake. Keeps a sticky overload flag and a
//                saturating dropped-request counter that are reported in the
//                last frame word and cleared when that word is accepted.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clock      in   sole clock
//    reset      in   synchronous active-high reset
//    dc         in   [15:0] signed DC estimate
//    peak       in   [15:0] unsigned peak amplitude
//    power      in   [31:0] unsigned average power
//    req        in   single-cycle snapshot request
//    out_data   out  [15:0] frame word
//    out_valid  out  out_data holds a valid word
//    out_ready  in   consumer accepts the word when high with out_valid
//    out_last   out  high with the final frame word
//    busy       out  a frame is in progress
//    overload   out  sticky overload flag (live)
// ============================================================================
module adc_stats_framer
    import adc_stats_pkg::*;
#(
    parameter logic [15:0] OVL_THRESH       = 16'd32000,
    parameter logic [7:0]  HEADER           = HEADER_DEFAULT,
    parameter int          AUTO_PERIOD_BITS = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [15:0] dc,
    input  logic        [15:0] peak,
    input  logic        [31:0] power,
    input  logic               req,
    output logic        [15:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               overload
);

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [15:0] r_snap_dc;
    logic [15:0] r_snap_peak;
    logic [31:0] r_snap_power;
    logic [7:0]  r_seq;
    logic [3:0]  r_dropped;
    logic        r_ovl;
    logic [15:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_last;

    logic        w_tick;
    logic        w_eff_req;
    logic        w_accept;
    logic        w_accept_last;
    logic        w_ovl_set;
    logic        w_drop;
    logic        w_ovl_nxt;
    logic [3:0]  w_drop_nxt;
    logic [2:0]  w_idx_nxt;
    logic [15:0] w_next_word;

    stats_req_timer #(
        .PERIOD_BITS (AUTO_PERIOD_BITS)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_eff_req     = req | w_tick;
    assign w_accept      = r_out_valid & out_ready;
    assign w_accept_last = w_accept & (r_idx == W_FLAGS);
    assign w_ovl_set     = (peak >= OVL_THRESH);
    // Any request seen while a frame is in flight is lost, including one on
    // the very edge the last word is accepted.
    assign w_drop        = w_eff_req & (r_state == ST_SEND);

    // A new event on the clearing edge wins over the clear
    assign w_ovl_nxt = w_ovl_set | (r_ovl & ~w_accept_last);

    always_comb begin
        w_drop_nxt = r_dropped;
        if (w_accept_last) begin
            w_drop_nxt = w_drop ? 4'd1 : 4'd0;
        end else if (w_drop && (r_dropped != 4'hF)) begin
            w_drop_nxt = r_dropped + 4'd1;
        end
    end

    assign w_idx_nxt = r_idx + 3'd1;

    // Word presented after the current one is accepted. The flags word
    // captures overload/dropped as they stand after this edge, so events on
    // the loading edge are reported; the word then stays frozen while held.
    always_comb begin
        w_next_word = {HEADER, r_seq};
        case (w_idx_nxt)
            W_DC:     w_next_word = r_snap_dc;
            W_PEAK:   w_next_word = r_snap_peak;
            W_PWR_HI: w_next_word = r_snap_power[31:16];
            W_PWR_LO: w_next_word = r_snap_power[15:0];
            W_FLAGS:  w_next_word = {w_ovl_nxt, 3'b000, w_drop_nxt, 8'h00};
            default:  w_next_word = {HEADER, r_seq};
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= W_HDR;
            r_snap_dc    <= '0;
            r_snap_peak  <= '0;
            r_snap_power <= '0;
            r_seq        <= '0;
            r_dropped    <= '0;
            r_ovl        <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            r_ovl     <= w_ovl_nxt;
            r_dropped <= w_drop_nxt;

            case (r_state)
                ST_IDLE: begin
                    if (w_eff_req) begin
                        r_snap_dc    <= dc;
                        r_snap_peak  <= peak;
                        r_snap_power <= power;
                        r_idx        <= W_HDR;
                        r_out_data   <= {HEADER, r_seq};
                        r_out_valid  <= 1'b1;
                        r_out_last   <= 1'b0;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_accept) begin
                        if (r_idx == W_FLAGS) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_seq       <= r_seq + 8'd1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_idx      <= w_idx_nxt;
                            r_out_data <= w_next_word;
                            r_out_last <= (w_idx_nxt == W_FLAGS);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = (r_state == ST_SEND);
    assign overload  = r_ovl;

endmodule
`default_nettype wire

// File: doc/adc_stats_framer.md
Name: adc_stats_framer

Overview:
- Sits directly downstream of the ADC peak/DC/power detector stage.
- Snapshots the detector's three result outputs on request and serialises them into a fixed 6-word, 16-bit status frame for the host status path over a valid/ready handshake.
- Maintains a sticky ADC-overload flag and a dropped-request counter.
- Requests come from an external pulse or an optional internal periodic timer.

Parameters:
- OVL_THRESH, 16'd32000: peak at or above this value sets the sticky overload flag.
- HEADER, 8'hA5: constant in the upper byte of frame word 0.
- AUTO_PERIOD_BITS, 0: 0 disables auto requests; N>0 issues an internal request every 2^N clocks.

Ports:
- clock, input, 1: sole clock.
- reset, input, 1: synchronous, active-high.
- dc, input, 16: signed DC estimate from the detector.
- peak, input, 16: unsigned peak amplitude from the detector.
- power, input, 32: unsigned average power from the detector.
- req, input, 1: single-cycle snapshot request.
- out_data, output, 16: frame word.
- out_valid, output, 1: out_data holds a valid word.
- out_ready, input, 1: consumer accepts a word when high together with out_valid.
- out_last, output, 1: high with word 5.
- busy, output, 1: a frame is in progress.
- overload, output, 1: sticky overload flag, live view.

Behaviour:
- Reset values:
  - out_valid=0, out_last=0, busy=0, out_data=0.
  - overload=0, seq=0, dropped=0, auto counter=0.
  - A frame in progress is abandoned immediately; no partial words are emitted after reset.
- Request source: eff_req = req OR auto_tick.
  - auto_tick pulses for one cycle when the (AUTO_PERIOD_BITS)-bit free-running counter wraps to 0.
  - With AUTO_PERIOD_BITS=0, auto_tick=0 and no counter exists.
- FSM states: IDLE, SEND.
  - IDLE, eff_req=1 at edge n: register snap_dc, snap_peak, snap_power from the inputs sampled at edge n; word index=0; go to SEND.
  - From edge n+1: busy=1, out_valid=1, out_data=word 0. Latency is 1 clock.
  - SEND: the word index advances only on out_valid&out_ready.
  - Acceptance of word 5 returns the FSM to IDLE and increments seq by 1 (mod 256; 255 wraps to 0).
  - The first new frame may start on the edge after return to IDLE; back-to-back frames have one idle cycle.
- Handshake:
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never drops until the word is accepted.
- Frame layout, from the snapshot and never from live inputs:
  - w0 = {HEADER, seq}.
  - w1 = snap_dc.
  - w2 = snap_peak.
  - w3 = snap_power[31:16].
  - w4 = snap_power[15:0].
  - w5 = {overload, 3'b000, dropped[3:0], 8'h00}; out_last=1. overload and dropped are sampled while w5 is presented.
- Dropped requests:
  - eff_req while in SEND is ignored; dropped increments, saturating at 15.
  - An eff_req on the same edge the FSM leaves SEND counts as dropped; it does not start a frame.
- Overload flag:
  - Sets when peak >= OVL_THRESH (unsigned compare) on any clock.
  - Clears on acceptance of w5.
- Clear/set collision rules on acceptance of w5:
  - If the set condition or a drop occurs on that same edge, set wins: overload=1, or dropped=1 (the new drop counts).
  - Otherwise both are cleared.
- Snapshot isolation: input changes during SEND do not affect the frame in flight.

Decomposition:
- Shared package adc_stats_pkg holds:
  - FRAME_WORDS=6.
  - Word-index constants W_HDR, W_DC, W_PEAK, W_PWR_HI, W_PWR_LO, W_FLAGS.
  - State encoding for IDLE/SEND.
  - HEADER default.
- Sub-module: none required. The optional periodic request generator may be split out as stats_req_timer (counter plus wrap strobe).

Test Plan:
- Basic frame, out_ready tied 1:
  - Stimulus: dc=-5, peak=1000, power=32'h0001_2345; one-cycle req.
  - Response: out_valid rises the next clock; words A500, FFFB, 03E8, 0001, 2345, 0000 on consecutive clocks; out_last only on word 5; busy then falls; next frame header A501.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1 per clock; change all inputs mid-frame.
  - Response: each word is held while ready=0; no word skipped or repeated; values match the snapshot.
- Overload:
  - Stimulus: peak=32000 for one clock, then 100.
  - Response: overload=1 and stays set; next frame w5=8000; overload=0 after w5 is accepted.
  - Stimulus: repeat with peak=32000 held through w5 acceptance.
  - Response: overload stays 1.
- Dropped requests:
  - Stimulus: 3 req pulses during SEND.
  - Response: w5 of the current frame = 0300; next frame w5 = 0000.
  - Stimulus: 20 pulses during SEND.
  - Response: w5 = 0F00 (saturated).
- Seq wrap and reset:
  - Stimulus: send 256 frames.
  - Response: header of frame 257 = A500.
  - Stimulus: assert reset during word 2.
  - Response: out_valid=0 on the next clock; the following frame header is A500 and overload=0.
- Auto mode:
  - Stimulus: AUTO_PERIOD_BITS=6, req=0, out_ready=1.
  - Response: a frame starts every 64 clocks; no drops are recorded.
